adder_share_arbiter: RTL and testbench

- Round-robin arbiter that time-shares one external 32-bit ripple adder between two requesters, for example the PC+4 path and the branch-target path in the lab CPU datapath.
- Each cycle it grants at most one requester and steers that requester's operands onto the adder inputs.
- It registers the adder's sum together with the winner's ID, a valid pulse and a signed-overflow flag.
- It sits between the requesting datapath stages and the adder instance.

---
 rtl/adder_share_arbiter.sv | 70 +++++++
 tb/tb_adder_share_arbiter.sv | 180 ++++++++++++++++++
 2 files changed

// File: rtl/adder_share_arbiter.sv
// Round-robin arbiter time-sharing one external adder between two requesters.
// Registers the sum with the winner's ID, a valid pulse, signed overflow and a grant count.
module adder_share_arbiter #(
    parameter int WIDTH = 32
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             hold_i,
    input  logic             req0_i,
    input  logic [WIDTH-1:0] a0_i,
    input  logic [WIDTH-1:0] b0_i,
    input  logic             req1_i,
    input  logic [WIDTH-1:0] a1_i,
    input  logic [WIDTH-1:0] b1_i,
    output logic             gnt0_o,
    output logic             gnt1_o,
    output logic [WIDTH-1:0] add_src1_o,
    output logic [WIDTH-1:0] add_src2_o,
    input  logic [WIDTH-1:0] add_sum_i,
    output logic             res_valid_o,
    output logic             res_id_o,
    output logic [WIDTH-1:0] res_sum_o,
    output logic             res_ovf_o,
    output logic [15:0]      busy_cnt_o
);

    logic lp;      // ID of the most recent grant; the other side wins a tie
    logic gnt_any;
    logic ovf;

    always_comb begin
        gnt0_o = 1'b0;
        gnt1_o = 1'b0;
        if (!hold_i) begin
            gnt0_o = req0_i && (!req1_i || lp);
            gnt1_o = req1_i && (!req0_i || !lp);
        end
    end

    assign gnt_any = gnt0_o | gnt1_o;

    // Idle cycles leave requester 0's operands on the adder; nothing is captured.
    assign add_src1_o = gnt1_o ? a1_i : a0_i;
    assign add_src2_o = gnt1_o ? b1_i : b0_i;

    assign ovf = (add_src1_o[WIDTH-1] == add_src2_o[WIDTH-1]) &&
                 (add_sum_i[WIDTH-1] != add_src1_o[WIDTH-1]);

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            lp          <= 1'b1;
            res_valid_o <= 1'b0;
            res_id_o    <= 1'b0;
            res_sum_o   <= '0;
            res_ovf_o   <= 1'b0;
            busy_cnt_o  <= '0;
        end else if (gnt_any) begin
            lp          <= gnt1_o;
            res_valid_o <= 1'b1;
            res_id_o    <= gnt1_o;
            res_sum_o   <= add_sum_i;
            res_ovf_o   <= ovf;
            if (busy_cnt_o != 16'hFFFF)
                busy_cnt_o <= busy_cnt_o + 16'd1;
        end else begin
            res_valid_o <= 1'b0;
        end
    end

endmodule

// File: tb/tb_adder_share_arbiter.sv
// Directed self-checking bench for adder_share_arbiter; the external adder is
// modelled as a plain combinational sum of the steered operands.
module tb_adder_share_arbiter;

    localparam int WIDTH = 32;

    logic             clk_i = 1'b0;
    logic             rst_i;
    logic             hold_i;
    logic             req0_i, req1_i;
    logic [WIDTH-1:0] a0_i, b0_i, a1_i, b1_i;
    logic             gnt0_o, gnt1_o;
    logic [WIDTH-1:0] add_src1_o, add_src2_o, add_sum_i;
    logic             res_valid_o, res_id_o, res_ovf_o;
    logic [WIDTH-1:0] res_sum_o;
    logic [15:0]      busy_cnt_o;

    int total = 0;
    int bad   = 0;

    always #5 clk_i = ~clk_i;

    assign add_sum_i = add_src1_o + add_src2_o;

    adder_share_arbiter #(.WIDTH(WIDTH)) dut (
        .clk_i(clk_i), .rst_i(rst_i), .hold_i(hold_i),
        .req0_i(req0_i), .a0_i(a0_i), .b0_i(b0_i),
        .req1_i(req1_i), .a1_i(a1_i), .b1_i(b1_i),
        .gnt0_o(gnt0_o), .gnt1_o(gnt1_o),
        .add_src1_o(add_src1_o), .add_src2_o(add_src2_o), .add_sum_i(add_sum_i),
        .res_valid_o(res_valid_o), .res_id_o(res_id_o), .res_sum_o(res_sum_o),
        .res_ovf_o(res_ovf_o), .busy_cnt_o(busy_cnt_o)
    );

    task automatic tick;
        @(posedge clk_i);
        #1;
    endtask

    task automatic pulse_reset;
        rst_i = 1'b1;
        #1;
        rst_i = 1'b0;
        #1;
    endtask

    task automatic test_reset;
        total++; if (res_valid_o !== 1'b0) begin bad++; $display("FAIL reset_valid got %b want 0", res_valid_o); end
        total++; if (res_id_o !== 1'b0) begin bad++; $display("FAIL reset_id got %b want 0", res_id_o); end
        total++; if (res_sum_o !== 32'h0) begin bad++; $display("FAIL reset_sum got %h want 0", res_sum_o); end
        total++; if (res_ovf_o !== 1'b0) begin bad++; $display("FAIL reset_ovf got %b want 0", res_ovf_o); end
        total++; if (busy_cnt_o !== 16'h0) begin bad++; $display("FAIL reset_busy got %h want 0", busy_cnt_o); end
        rst_i = 1'b0;
        tick();
    endtask

    task automatic test_single;
        req0_i = 1'b1; a0_i = 32'd5; b0_i = 32'd7;
        #1;
        total++; if (gnt0_o !== 1'b1 || gnt1_o !== 1'b0) begin bad++; $display("FAIL single_gnt got %b%b want 10", gnt0_o, gnt1_o); end
        total++; if (add_src1_o !== 32'd5 || add_src2_o !== 32'd7) begin bad++; $display("FAIL single_steer got %h/%h want 5/7", add_src1_o, add_src2_o); end
        tick();
        req0_i = 1'b0;
        total++; if (res_valid_o !== 1'b1) begin bad++; $display("FAIL single_valid got %b want 1", res_valid_o); end
        total++; if (res_id_o !== 1'b0) begin bad++; $display("FAIL single_id got %b want 0", res_id_o); end
        total++; if (res_sum_o !== 32'd12) begin bad++; $display("FAIL single_sum got %h want c", res_sum_o); end
        total++; if (res_ovf_o !== 1'b0) begin bad++; $display("FAIL single_ovf got %b want 0", res_ovf_o); end
        total++; if (busy_cnt_o !== 16'd1) begin bad++; $display("FAIL single_busy got %h want 1", busy_cnt_o); end
        tick();
        total++; if (res_valid_o !== 1'b0) begin bad++; $display("FAIL idle_valid got %b want 0", res_valid_o); end
        total++; if (res_sum_o !== 32'd12) begin bad++; $display("FAIL idle_sum_hold got %h want c", res_sum_o); end
    endtask

    task automatic test_back_to_back;
        logic [WIDTH-1:0] exp_sum;
        pulse_reset();
        req0_i = 1'b1; a0_i = 32'd1; b0_i = 32'd1;
        req1_i = 1'b1; a1_i = 32'd2; b1_i = 32'd2;
        for (int i = 0; i < 4; i++) begin
            #1;
            total++; if (gnt0_o !== (i % 2 == 0) || gnt1_o !== (i % 2 == 1)) begin bad++; $display("FAIL rr_gnt[%0d] got %b%b want %b%b", i, gnt0_o, gnt1_o, i % 2 == 0, i % 2 == 1); end
            tick();
            exp_sum = (i % 2 == 0) ? 32'd2 : 32'd4;
            total++; if (res_id_o !== 1'(i % 2) || res_valid_o !== 1'b1) begin bad++; $display("FAIL rr_id[%0d] got %b v=%b want %0d v=1", i, res_id_o, res_valid_o, i % 2); end
            total++; if (res_sum_o !== exp_sum) begin bad++; $display("FAIL rr_sum[%0d] got %h want %h", i, res_sum_o, exp_sum); end
        end
        req0_i = 1'b0; req1_i = 1'b0;
        total++; if (busy_cnt_o !== 16'd4) begin bad++; $display("FAIL rr_busy got %h want 4", busy_cnt_o); end
    endtask

    task automatic test_overflow;
        req1_i = 1'b1; a1_i = 32'h7FFFFFFF; b1_i = 32'd1;
        tick();
        req1_i = 1'b0;
        total++; if (res_sum_o !== 32'h80000000 || res_id_o !== 1'b1) begin bad++; $display("FAIL ovf_pos_sum got %h id=%b want 80000000 id=1", res_sum_o, res_id_o); end
        total++; if (res_ovf_o !== 1'b1) begin bad++; $display("FAIL ovf_pos_flag got %b want 1", res_ovf_o); end
        req0_i = 1'b1; a0_i = 32'hFFFFFFFF; b0_i = 32'd1;
        tick();
        total++; if (res_sum_o !== 32'h0 || res_id_o !== 1'b0) begin bad++; $display("FAIL wrap_sum got %h id=%b want 0 id=0", res_sum_o, res_id_o); end
        total++; if (res_ovf_o !== 1'b0) begin bad++; $display("FAIL wrap_ovf got %b want 0", res_ovf_o); end
        a0_i = 32'h80000000; b0_i = 32'h80000000;
        tick();
        req0_i = 1'b0;
        total++; if (res_sum_o !== 32'h0 || res_ovf_o !== 1'b1) begin bad++; $display("FAIL ovf_neg got %h ovf=%b want 0 ovf=1", res_sum_o, res_ovf_o); end
        total++; if (busy_cnt_o !== 16'd7) begin bad++; $display("FAIL ovf_busy got %h want 7", busy_cnt_o); end
    endtask

    task automatic test_hold;
        hold_i = 1'b1;
        req0_i = 1'b1; a0_i = 32'd1; b0_i = 32'd1;
        req1_i = 1'b1; a1_i = 32'd2; b1_i = 32'd2;
        for (int i = 0; i < 3; i++) begin
            #1;
            total++; if (gnt0_o !== 1'b0 || gnt1_o !== 1'b0) begin bad++; $display("FAIL hold_gnt[%0d] got %b%b want 00", i, gnt0_o, gnt1_o); end
            tick();
            total++; if (res_valid_o !== 1'b0) begin bad++; $display("FAIL hold_valid[%0d] got %b want 0", i, res_valid_o); end
            total++; if (res_sum_o !== 32'h0 || res_ovf_o !== 1'b1 || res_id_o !== 1'b0 || busy_cnt_o !== 16'd7) begin
                bad++; $display("FAIL hold_keep[%0d] got sum=%h ovf=%b id=%b busy=%h want 0/1/0/7", i, res_sum_o, res_ovf_o, res_id_o, busy_cnt_o);
            end
        end
        hold_i = 1'b0;
        #1;
        total++; if (gnt0_o !== 1'b0 || gnt1_o !== 1'b1) begin bad++; $display("FAIL unhold_gnt got %b%b want 01", gnt0_o, gnt1_o); end
        tick();
        total++; if (res_id_o !== 1'b1 || res_sum_o !== 32'd4) begin bad++; $display("FAIL unhold_res got id=%b sum=%h want 1/4", res_id_o, res_sum_o); end
        total++; if (gnt0_o !== 1'b1 || gnt1_o !== 1'b0) begin bad++; $display("FAIL unhold_next got %b%b want 10", gnt0_o, gnt1_o); end
        tick();
        total++; if (res_id_o !== 1'b0 || res_sum_o !== 32'd2 || busy_cnt_o !== 16'd9) begin
            bad++; $display("FAIL unhold_res2 got id=%b sum=%h busy=%h want 0/2/9", res_id_o, res_sum_o, busy_cnt_o);
        end
    endtask

    task automatic test_async_reset;
        // both requests still high, lp=0: requester 1 is granted this cycle
        total++; if (res_valid_o !== 1'b1 || gnt1_o !== 1'b1) begin bad++; $display("FAIL pre_reset got v=%b g1=%b want 1/1", res_valid_o, gnt1_o); end
        #2;
        rst_i = 1'b1;
        #1;
        total++; if (res_valid_o !== 1'b0 || res_sum_o !== 32'h0 || res_id_o !== 1'b0 || res_ovf_o !== 1'b0) begin
            bad++; $display("FAIL async_clear got v=%b sum=%h id=%b ovf=%b want 0", res_valid_o, res_sum_o, res_id_o, res_ovf_o);
        end
        total++; if (busy_cnt_o !== 16'h0) begin bad++; $display("FAIL async_busy got %h want 0", busy_cnt_o); end
        rst_i = 1'b0;
        #1;
        total++; if (gnt0_o !== 1'b1 || gnt1_o !== 1'b0) begin bad++; $display("FAIL post_reset_gnt got %b%b want 10", gnt0_o, gnt1_o); end
        tick();
        total++; if (res_id_o !== 1'b0 || res_sum_o !== 32'd2 || busy_cnt_o !== 16'd1) begin
            bad++; $display("FAIL post_reset_res got id=%b sum=%h busy=%h want 0/2/1", res_id_o, res_sum_o, busy_cnt_o);
        end
        req0_i = 1'b0; req1_i = 1'b0;
    endtask

    task automatic test_saturate;
        pulse_reset();
        req0_i = 1'b1; a0_i = 32'd3; b0_i = 32'd4;
        repeat (65534) tick();
        total++; if (busy_cnt_o !== 16'hFFFE) begin bad++; $display("FAIL sat_pre got %h want fffe", busy_cnt_o); end
        repeat (6) tick();
        total++; if (busy_cnt_o !== 16'hFFFF) begin bad++; $display("FAIL sat_hold got %h want ffff", busy_cnt_o); end
        total++; if (res_valid_o !== 1'b1 || res_sum_o !== 32'd7) begin bad++; $display("FAIL sat_res got v=%b sum=%h want 1/7", res_valid_o, res_sum_o); end
        req0_i = 1'b0;
    endtask

    initial begin
        rst_i = 1'b1; hold_i = 1'b0;
        req0_i = 1'b0; req1_i = 1'b0;
        a0_i = '0; b0_i = '0; a1_i = '0; b1_i = '0;
        #12;
        test_reset();
        test_single();
        test_back_to_back();
        test_overflow();
        test_hold();
        test_async_reset();
        test_saturate();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
